// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller: paces the CPU with a one-cycle clock enable,
// supports free-run rate, single-step, PC breakpoint and a cycle counter.
module cpu_run_ctrl #(
    parameter int DIV_W      = 24,
    parameter int DEB_CYCLES = 16,
    parameter int PC_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             clr_cnt,
    output logic             cpu_ce,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [31:0]      cycle_count
);

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             run_s1;
    logic             run_sync;
    logic             step_s1;
    logic             step_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;
    logic             step_evt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             bp_match;
    logic             skip;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt;
    logic             ce_nxt;
    logic             skip_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_s1    <= 1'b0;
            run_sync  <= 1'b0;
            step_s1   <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            run_s1    <= run_sw;
            run_sync  <= run_s1;
            step_s1   <= step_btn;
            step_sync <= step_s1;
        end
    end

    // Level is accepted after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            step_evt  <= 1'b0;
        end else begin
            step_evt <= 1'b0;
            if (step_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                deb_level <= step_sync;
                step_evt  <= step_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign tick     = (state_r == S_RUN) && (div_cnt == div_sel);
    assign bp_match = bp_en && (pc == bp_addr) && !skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (state_r != S_RUN || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        state_nxt = state_r;
        ce_nxt    = 1'b0;
        skip_set  = 1'b0;
        unique case (1'b1)
            (state_r == S_HALT): begin
                if (run_sync)      state_nxt = S_RUN;
                else if (step_evt) state_nxt = S_STEP;
            end
            (state_r == S_RUN): begin
                if (!run_sync) begin
                    state_nxt = S_HALT;
                end else if (tick && bp_match) begin
                    state_nxt = S_BREAK;
                    skip_set  = 1'b1;
                end else if (tick) begin
                    ce_nxt = 1'b1;
                end
            end
            (state_r == S_STEP): begin
                state_nxt = S_HALT;
            end
            (state_r == S_BREAK): begin
                if (!run_sync)     state_nxt = S_HALT;
                else if (step_evt) state_nxt = S_STEP;
            end
        endcase
        // The STEP cycle itself carries the enable pulse.
        if (state_nxt == S_STEP) ce_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_HALT;
            cpu_ce  <= 1'b0;
            skip    <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cpu_ce  <= ce_nxt;
            if (skip_set)    skip <= 1'b1;
            else if (ce_nxt) skip <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (clr_cnt) begin
            cycle_count <= '0;
        end else if (cpu_ce && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign state  = state_r;
    assign halted = (state_r == S_HALT) || (state_r == S_BREAK);
    assign bp_hit = (state_r == S_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a small CPU pc model and a queue of
// expected executed-instruction addresses checked on every cpu_ce pulse.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic [23:0] div_sel;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        clr_cnt;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int          checks = 0;
    int          errors = 0;
    int          ce_total = 0;
    int          cyc = 0;
    int          last_ce = -1;
    bit          chk_period = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] pc_reg = 32'd0;
    logic [31:0] pc_load_val = 32'd0;
    bit          pc_load = 1'b0;
    bit          loop_en = 1'b0;

    cpu_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .div_sel    (div_sel),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .clr_cnt    (clr_cnt),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .state      (state),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return (loop_en && p == 32'h18) ? 32'h10 : p + 32'd4;
    endfunction

    // CPU model: pc presents the next instruction while its ce is high.
    always @(posedge clk) begin
        if (pc_load)     pc_reg <= pc_load_val;
        else if (cpu_ce) pc_reg <= nxt(pc_reg);
    end
    assign pc = cpu_ce ? nxt(pc_reg) : pc_reg;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ce_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (cpu_ce === 1'b1) begin
                check("ce_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ce_pc", pc_reg, e);
                end
                if (chk_period && last_ce >= 0)
                    check("ce_period", 32'(cyc - last_ce), 32'd4);
                last_ce  = cyc;
                ce_total = ce_total + 1;
            end
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load_val = v;
        pc_load = 1'b1;
        tick_n(1);
        pc_load = 1'b0;
    endtask

    task automatic wait_ce(input int target, input int budget, input string tag);
        int n = 0;
        while (ce_total < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, 32'(ce_total), 32'(target));
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick_n(1);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic run_pulses(input int n, input bit clr_last);
        int p = 0;
        int b = 0;
        run_sw = 1'b1;
        while (p < n && b < 200) begin
            @(posedge clk);
            #1;
            b++;
            if (cpu_ce) begin
                p++;
                if (p == n) begin
                    clr_cnt = clr_last;
                    run_sw  = 1'b0;
                end
            end
        end
        tick_n(1);
        clr_cnt = 1'b0;
        check("run_pulses", 32'(p), 32'(n));
    endtask

    task automatic step_latency(input int expect_k);
        int k = 0;
        step_btn = 1'b1;
        while (state !== 2'b10 && k < 40) begin
            tick_n(1);
            k++;
        end
        check("step_latency", 32'(k), 32'(expect_k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_step;
        rst = 1'b0;
        run_sw = 1'b0;
        step_btn = 1'b0;
        div_sel = '0;
        bp_en = 1'b0;
        bp_addr = '0;
        clr_cnt = 1'b0;
        fork
            ce_monitor();
        join_none
        tick_n(2);
        load_pc(32'h0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_count", cycle_count, 32'd0);
        rst = 1'b1;

        tick_n(1000);
        check("idle_ce", 32'(ce_total), 32'd0);
        check("idle_state", 32'(state), 32'd0);
        check("idle_count", cycle_count, 32'd0);

        div_sel = 24'd3;
        for (int i = 0; i < 40; i++) exp_q.push_back(32'(i * 4));
        chk_period = 1'b1;
        run_sw = 1'b1;
        tick_n(2);
        check("run_lat2", 32'(state), 32'd0);
        tick_n(1);
        check("run_lat3", 32'(state), 32'd1);
        wait_ce(40, 400, "run40");
        check("run40_count", cycle_count, 32'd40);
        run_sw = 1'b0;
        tick_n(3);
        chk_period = 1'b0;
        check("run_off_state", 32'(state), 32'd0);
        check("run_off_halted", 32'(halted), 32'd1);
        tick_n(50);
        check("run_off_ce", 32'(ce_total), 32'd40);

        load_pc(32'h200);
        exp_q.push_back(32'h200);
        for (int i = 0; i < 10; i++) begin
            step_btn = ~step_btn;
            tick_n(1);
        end
        step_btn = 1'b1;
        saw_step = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick_n(1);
            if (state == 2'b10) saw_step = 1'b1;
        end
        check("bounce_step_seen", 32'(saw_step), 32'd1);
        check("bounce_ce", 32'(ce_total), 32'd41);
        check("bounce_count", cycle_count, 32'd41);
        check("bounce_state", 32'(state), 32'd0);
        check("bounce_pc", pc_reg, 32'h204);
        tick_n(50);
        check("hold_ce", 32'(ce_total), 32'd41);
        step_btn = 1'b0;
        tick_n(30);
        check("release_ce", 32'(ce_total), 32'd41);

        load_pc(32'h0);
        div_sel = 24'd0;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        run_sw = 1'b1;
        wait_state(2'b11, 100, "bp_break");
        check("bp_ce", 32'(ce_total), 32'd45);
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_pc", pc, 32'h10);
        check("bp_count", cycle_count, 32'd45);
        run_sw = 1'b0;
        tick_n(3);
        check("bp_off_state", 32'(state), 32'd0);
        check("bp_off_hit", 32'(bp_hit), 32'd0);

        exp_q.push_back(32'h10);
        step_latency(19);
        tick_n(1);
        check("bp_step_state", 32'(state), 32'd0);
        check("bp_step_pc", pc, 32'h14);
        check("bp_step_ce", 32'(ce_total), 32'd46);
        step_btn = 1'b0;
        tick_n(30);

        loop_en = 1'b1;
        exp_q.push_back(32'h14);
        exp_q.push_back(32'h18);
        run_sw = 1'b1;
        wait_state(2'b11, 100, "loop_break");
        check("loop_pc", pc, 32'h10);
        check("loop_ce", 32'(ce_total), 32'd48);
        run_sw = 1'b0;
        wait_state(2'b00, 10, "loop_halt");
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        exp_q.push_back(32'h18);
        run_sw = 1'b1;
        wait_state(2'b11, 100, "skip_rebreak");
        check("skip_ce", 32'(ce_total), 32'd51);
        check("skip_pc", pc, 32'h10);

        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        exp_q.push_back(32'h18);
        step_btn = 1'b1;
        wait_ce(54, 100, "bk_step_ce");
        wait_state(2'b11, 50, "bk_step_rebreak");
        check("bk_step_pc", pc, 32'h10);
        step_btn = 1'b0;
        run_sw = 1'b0;
        wait_state(2'b00, 10, "bk_step_halt");
        tick_n(30);
        loop_en = 1'b0;
        bp_en = 1'b0;

        div_sel = 24'd3;
        load_pc(32'h40);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        run_pulses(2, 1'b1);
        check("clr_wins", cycle_count, 32'd0);
        tick_n(5);
        check("clr_ce", 32'(ce_total), 32'd56);
        check("clr_state", 32'(state), 32'd0);

        force dut.cycle_count = 32'hFFFF_FFFE;
        tick_n(1);
        release dut.cycle_count;
        tick_n(1);
        check("sat_preset", cycle_count, 32'hFFFF_FFFE);
        exp_q.push_back(32'h48);
        exp_q.push_back(32'h4C);
        exp_q.push_back(32'h50);
        run_pulses(3, 1'b0);
        tick_n(3);
        check("sat_count", cycle_count, 32'hFFFF_FFFF);

        begin
            int b = 0;
            run_sw = 1'b1;
            while (cpu_ce !== 1'b1 && b < 100) begin
                tick_n(1);
                b++;
            end
        end
        check("mid_ce_seen", 32'(cpu_ce), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ce", 32'(cpu_ce), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd1);
        check("mid_rst_bp_hit", 32'(bp_hit), 32'd0);
        check("mid_rst_count", cycle_count, 32'd0);
        run_sw = 1'b0;
        tick_n(2);
        rst = 1'b1;
        tick_n(10);
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_ce", 32'(ce_total), 32'd59);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
